// File: rtl/pkt_rr_mux.sv
// rtl/pkt_rr_mux.sv - round-robin packet-granular mux of CH_NUM valid/ready streams onto one
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid[k]     : channel k beat valid
//   in_data         : channel k data at [k*DATA_WID +: DATA_WID]
//   in_last[k]      : channel k end-of-packet
//   in_ready[k]     : channel k ready (only the granted channel, only while out_ready)
//   out_valid/out_data/out_last : merged stream towards the TX datapath
//   out_id          : channel currently granted
//   out_ready       : downstream ready
//   dbg_sig         : {state, cur_id, pkt_cnt}, zero-extended or truncated to DBG_WID

module pkt_rr_mux #(
    parameter int CH_NUM   = 4,
    parameter int DATA_WID = 64,
    parameter int ID_WID   = 2,
    parameter int DBG_WID  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH_NUM-1:0]            in_valid,
    input  logic [CH_NUM*DATA_WID-1:0]   in_data,
    input  logic [CH_NUM-1:0]            in_last,
    output logic [CH_NUM-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WID-1:0]          out_data,
    output logic                         out_last,
    output logic [ID_WID-1:0]            out_id,
    input  logic                         out_ready,
    output logic [DBG_WID-1:0]           dbg_sig
);

    // One extra bit so (start + offset) can exceed CH_NUM before the wrap.
    localparam int SW    = ID_WID + 1;
    localparam int RAW_W = 2 + ID_WID + 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01
    } state_t;

    state_t              state;
    logic [CH_NUM-1:0]   gnt;
    logic [ID_WID-1:0]   cur_id;
    logic [ID_WID-1:0]   last_id;
    logic [15:0]         pkt_cnt;

    logic                xfer;
    logic [SW-1:0]       start;
    logic [2*CH_NUM-1:0] req_dbl;
    logic [CH_NUM-1:0]   req_rot;
    logic [SW-1:0]       win_sum;
    logic [ID_WID-1:0]   win_id;
    logic [CH_NUM-1:0]   win_oh;
    logic                sel_valid;
    logic                pkt_done;
    logic [RAW_W-1:0]    dbg_raw;

    assign xfer = (state == XFER);

    // Round-robin search: rotate the request vector so bit 0 is the channel
    // after last_id, pick the lowest set bit, then map back to a channel id.
    // When only last_id requests, it lands at the top of the rotation and
    // still wins.
    always_comb begin
        start   = (last_id == ID_WID'(CH_NUM - 1)) ? '0 : SW'(last_id) + SW'(1);
        req_dbl = {in_valid, in_valid};
        req_rot = CH_NUM'(req_dbl >> start);
        win_sum = start;
        for (int j = CH_NUM - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_sum = start + SW'(j);
            end
        end
        if (win_sum >= SW'(CH_NUM)) begin
            win_sum = win_sum - SW'(CH_NUM);
        end
        win_id = win_sum[ID_WID-1:0];
        win_oh = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            win_oh[k] = (win_id == ID_WID'(k));
        end
    end

    // One-hot AND-OR select driven by the registered grant; no data register,
    // so a granted beat passes straight through.
    always_comb begin
        out_data  = '0;
        out_last  = 1'b0;
        sel_valid = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (gnt[k]) begin
                out_data  = out_data | in_data[k*DATA_WID +: DATA_WID];
                out_last  = out_last | in_last[k];
                sel_valid = sel_valid | in_valid[k];
            end
        end
        if (!xfer) begin
            out_data  = '0;
            out_last  = 1'b0;
            sel_valid = 1'b0;
        end
    end

    assign out_valid = xfer & sel_valid;
    assign out_id    = cur_id;
    assign in_ready  = gnt & {CH_NUM{xfer & out_ready}};
    assign pkt_done  = out_valid & out_ready & out_last;

    // Grant is only released on the accepted last beat; bubbles and
    // backpressure keep it, and other requesters are ignored until IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            cur_id  <= '0;
            last_id <= ID_WID'(CH_NUM - 1);
            pkt_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|in_valid) begin
                        cur_id <= win_id;
                        gnt    <= win_oh;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    if (pkt_done) begin
                        last_id <= cur_id;
                        pkt_cnt <= pkt_cnt + 16'd1;
                        gnt     <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_raw = {state, cur_id, pkt_cnt};

    generate
        if (DBG_WID > RAW_W) begin : g_dbg_ext
            assign dbg_sig = {{(DBG_WID - RAW_W){1'b0}}, dbg_raw};
        end else if (DBG_WID == RAW_W) begin : g_dbg_eq
            assign dbg_sig = dbg_raw;
        end else begin : g_dbg_trunc
            assign dbg_sig = dbg_raw[DBG_WID-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_pkt_rr_mux.sv
// tb/tb_pkt_rr_mux.sv - directed self-checking bench for pkt_rr_mux
module tb_pkt_rr_mux;

    localparam int CH = 4;
    localparam int DW = 64;
    localparam int IW = 2;
    localparam int BW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     in_valid;
    logic [CH*DW-1:0]  in_data;
    logic [CH-1:0]     in_last;
    logic [CH-1:0]     in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [IW-1:0]     out_id;
    logic              out_ready;
    logic [BW-1:0]     dbg_sig;

    int n_checks = 0;
    int n_pass   = 0;
    int bcnt [CH];
    int plen [CH];
    logic [CH-1:0] fire;

    pkt_rr_mux #(.CH_NUM(CH), .DATA_WID(DW), .ID_WID(IW), .DBG_WID(BW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_id(out_id),
        .out_ready(out_ready), .dbg_sig(dbg_sig)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int k, input int n);
        logic [31:0] a;
        logic [31:0] b;
        a = k;
        b = n;
        return {a, b};
    endfunction

    // Each channel emits beat n as {k, n}; last flag every plen[k] beats.
    task automatic drive_src();
        for (int k = 0; k < CH; k++) begin
            in_data[k*DW +: DW] = mk(k, bcnt[k]);
            in_last[k] = ((bcnt[k] % plen[k]) == plen[k] - 1);
        end
    endtask

    // Called at negedge+1 after checks; returns at the following negedge.
    task automatic cyc();
        fire = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) if (fire[k]) bcnt[k]++;
        drive_src();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        for (int k = 0; k < CH; k++) begin
            bcnt[k] = 0;
            plen[k] = 1;
        end
        drive_src();
        #1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < CH; k++) plen[k] = 2;
        drive_src();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid cyc=%0d got=%b want=0", i, out_valid); else n_pass++;
            n_checks++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready cyc=%0d got=%b want=0000", i, in_ready); else n_pass++;
            n_checks++; if (dbg_sig[15:0] !== 16'd0) $display("FAIL reset_pkt_cnt cyc=%0d got=%0d want=0", i, dbg_sig[15:0]); else n_pass++;
            cyc();
        end
        rst = 1'b0;
        #1;
        n_checks++; if (dbg_sig[19:18] !== 2'b00) $display("FAIL reset_state got=%b want=00", dbg_sig[19:18]); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_idle_valid got=%b want=0", out_valid); else n_pass++;
        cyc();
        #1;
        n_checks++; if (out_id !== 2'd0) $display("FAIL reset_first_grant got=%0d want=0", out_id); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL reset_first_valid got=%b want=1", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 4'b0001) $display("FAIL reset_first_ready got=%b want=0001", in_ready); else n_pass++;
    endtask

    task automatic test_fair_rotation();
        int id;
        int idx;
        apply_reset();
        for (int k = 0; k < CH; k++) plen[k] = 2;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        drive_src();
        for (int p = 0; p < 5; p++) begin
            id = p % 4;
            idx = 2 * (p / 4);
            #1;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL fair_idle pkt=%0d got=%b want=0", p, out_valid); else n_pass++;
            cyc();
            #1;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL fair_valid pkt=%0d got=%b want=1", p, out_valid); else n_pass++;
            n_checks++; if (out_id !== IW'(id)) $display("FAIL fair_id pkt=%0d got=%0d want=%0d", p, out_id, id); else n_pass++;
            n_checks++; if (out_data !== mk(id, idx)) $display("FAIL fair_data0 pkt=%0d got=%h want=%h", p, out_data, mk(id, idx)); else n_pass++;
            n_checks++; if (out_last !== 1'b0) $display("FAIL fair_last0 pkt=%0d got=%b want=0", p, out_last); else n_pass++;
            cyc();
            #1;
            n_checks++; if (out_data !== mk(id, idx + 1)) $display("FAIL fair_data1 pkt=%0d got=%h want=%h", p, out_data, mk(id, idx + 1)); else n_pass++;
            n_checks++; if (out_last !== 1'b1) $display("FAIL fair_last1 pkt=%0d got=%b want=1", p, out_last); else n_pass++;
            cyc();
        end
        #1;
        n_checks++; if (dbg_sig[15:0] !== 16'd5) $display("FAIL fair_pkt_cnt got=%0d want=5", dbg_sig[15:0]); else n_pass++;
    endtask

    task automatic test_skip();
        logic [3:0] iv_t [0:11];
        logic       ov_t [0:11];
        int         id_t [0:11];
        iv_t = '{4'b0010, 4'b0010, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
        ov_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        id_t = '{0, 1, 0, 3, 0, 0, 0, 2, 0, 2, 0, 2};
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = iv_t[c];
            drive_src();
            #1;
            n_checks++; if (out_valid !== ov_t[c]) $display("FAIL skip_valid cyc=%0d got=%b want=%b", c, out_valid, ov_t[c]); else n_pass++;
            if (ov_t[c]) begin
                n_checks++; if (out_id !== IW'(id_t[c])) $display("FAIL skip_id cyc=%0d got=%0d want=%0d", c, out_id, id_t[c]); else n_pass++;
                n_checks++; if (out_last !== 1'b1) $display("FAIL skip_last cyc=%0d got=%b want=1", c, out_last); else n_pass++;
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] iv_t  [0:10];
        logic       rdy_t [0:10];
        logic       ov_t  [0:10];
        logic       lst_t [0:10];
        logic [3:0] ir_t  [0:10];
        int         di_t  [0:10];
        iv_t  = '{4'b0010, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                  4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b0000};
        rdy_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ov_t  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        lst_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ir_t  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        di_t  = '{0, 0, 1, 1, 1, 1, 0, 0, 2, 3, 0};
        apply_reset();
        plen[1] = 4;
        for (int c = 0; c < 11; c++) begin
            in_valid = iv_t[c];
            out_ready = rdy_t[c];
            drive_src();
            #1;
            n_checks++; if (out_valid !== ov_t[c]) $display("FAIL bp_valid cyc=%0d got=%b want=%b", c, out_valid, ov_t[c]); else n_pass++;
            n_checks++; if (in_ready !== ir_t[c]) $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", c, in_ready, ir_t[c]); else n_pass++;
            n_checks++; if (out_last !== lst_t[c]) $display("FAIL bp_last cyc=%0d got=%b want=%b", c, out_last, lst_t[c]); else n_pass++;
            if (ov_t[c]) begin
                n_checks++; if (out_data !== mk(1, di_t[c])) $display("FAIL bp_data cyc=%0d got=%h want=%h", c, out_data, mk(1, di_t[c])); else n_pass++;
            end
            if (c >= 1 && c <= 9) begin
                n_checks++; if (out_id !== 2'd1) $display("FAIL bp_id cyc=%0d got=%0d want=1", c, out_id); else n_pass++;
            end
            cyc();
        end
        #1;
        n_checks++; if (dbg_sig[15:0] !== 16'd1) $display("FAIL bp_pkt_cnt got=%0d want=1", dbg_sig[15:0]); else n_pass++;
    endtask

    task automatic test_single_beat();
        apply_reset();
        in_valid = 4'b0101;
        out_ready = 1'b1;
        drive_src();
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c % 2 == 1) begin
                n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid cyc=%0d got=%b want=1", c, out_valid); else n_pass++;
                n_checks++; if (out_last !== 1'b1) $display("FAIL single_last cyc=%0d got=%b want=1", c, out_last); else n_pass++;
                n_checks++; if (out_id !== ((c % 4 == 1) ? 2'd0 : 2'd2)) $display("FAIL single_id cyc=%0d got=%0d want=%0d", c, out_id, (c % 4 == 1) ? 0 : 2); else n_pass++;
            end else begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL single_idle cyc=%0d got=%b want=0", c, out_valid); else n_pass++;
                n_checks++; if (dbg_sig[15:0] !== 16'(c / 2)) $display("FAIL single_pkt_cnt cyc=%0d got=%0d want=%0d", c, dbg_sig[15:0], c / 2); else n_pass++;
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        plen[3] = 4;
        in_valid = 4'b1000;
        out_ready = 1'b1;
        drive_src();
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_idle got=%b want=0", out_valid); else n_pass++;
        cyc();
        #1;
        n_checks++; if (out_id !== 2'd3) $display("FAIL mid_id got=%0d want=3", out_id); else n_pass++;
        n_checks++; if (out_data !== mk(3, 0)) $display("FAIL mid_data0 got=%h want=%h", out_data, mk(3, 0)); else n_pass++;
        cyc();
        #1;
        n_checks++; if (out_data !== mk(3, 1)) $display("FAIL mid_data1 got=%h want=%h", out_data, mk(3, 1)); else n_pass++;
        n_checks++; if (dbg_sig[17:16] !== 2'd3) $display("FAIL mid_cur_id got=%0d want=3", dbg_sig[17:16]); else n_pass++;
        cyc();
        rst = 1'b1;
        #1;
        cyc();
        rst = 1'b0;
        in_valid = 4'b1001;
        drive_src();
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_after_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++; if (dbg_sig[19:18] !== 2'b00) $display("FAIL mid_after_state got=%b want=00", dbg_sig[19:18]); else n_pass++;
        n_checks++; if (in_ready !== 4'b0000) $display("FAIL mid_after_ready got=%b want=0000", in_ready); else n_pass++;
        cyc();
        #1;
        n_checks++; if (out_id !== 2'd0) $display("FAIL mid_regrant_id got=%0d want=0", out_id); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_regrant_valid got=%b want=1", out_valid); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        for (int k = 0; k < CH; k++) begin
            bcnt[k] = 0;
            plen[k] = 1;
        end
        drive_src();
        @(negedge clk);
        test_reset();
        test_fair_rotation();
        test_skip();
        test_backpressure();
        test_single_beat();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_rr_mux.md
Name: pkt_rr_mux

Overview:
- Shares one outbound packet stream between CH_NUM inbound valid/ready packet streams, with round-robin fairness.
- A grant is held for a whole packet, from the first beat through the beat with last=1.
- Sits in front of the TOE TX datapath: per-connection or per-queue packet sources feed one MAC/checksum pipeline.
- Registered grant, combinational data path through a one-hot mux; adds no data latency once granted.

Parameters:
- CH_NUM, 4, number of input channels (2..16).
- DATA_WID, 64, data bus width per channel.
- ID_WID, 2, width of the channel id; must be ≥ ceil(log2(CH_NUM)).
- DBG_WID, 32, debug bus width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  CH_NUM  per-channel beat valid.
- in_data  input  CH_NUM*DATA_WID  per-channel data; channel k occupies bits [k*DATA_WID +: DATA_WID].
- in_last  input  CH_NUM  per-channel end-of-packet flag.
- in_ready  output  CH_NUM  per-channel ready.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_WID  output data.
- out_last  output  1  output end-of-packet flag.
- out_id  output  ID_WID  index of the channel currently granted.
- out_ready  input  1  downstream ready.
- dbg_sig  output  DBG_WID  debug: {state[1:0], cur_id, pkt_cnt[15:0]}, zero-extended or truncated to DBG_WID.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All registers clear on the rst=1 clock edge.
- Reset values:
  - state=IDLE, gnt=0, cur_id=0, last_id=CH_NUM-1 (so channel 0 wins first), pkt_cnt=0.
  - Outputs: out_valid=0, in_ready=0, out_last=0, out_id=0.
- Handshake:
  - A beat transfers when valid and ready are both high on a clk edge.
  - in_ready[k] = (state==XFER) & gnt[k] & out_ready. This is combinational from out_ready.
  - out_valid = (state==XFER) & in_valid[cur_id].
  - out_data = in_data[cur_id] and out_last = in_last[cur_id] when in XFER; both are 0 otherwise.
  - out_id = cur_id.
- Round-robin search:
  - Search order is (last_id+1) mod CH_NUM, then ascending with wrap-around, ending at last_id.
  - The first channel with in_valid=1 wins.
  - With a single requester, that requester always wins, including when it equals last_id.
- FSM:
  - IDLE: if |in_valid, latch cur_id = search result, set gnt = onehot(cur_id), go to XFER. Otherwise stay in IDLE.
  - XFER, on an accepted beat (out_valid & out_ready) with out_last=1:
    - last_id <= cur_id
    - pkt_cnt <= pkt_cnt+1 (wraps at 2^16)
    - gnt <= 0
    - go to IDLE.
  - XFER, otherwise: stay in XFER. Bubbles (in_valid[cur_id]=0) and backpressure (out_ready=0) never drop the grant.
- Latency:
  - First beat can transfer the cycle after arbitration (1-cycle arbitration).
  - One idle cycle between consecutive packets (last beat, then IDLE, then next XFER).
- Non-granted channels see in_ready=0 at all times.
- Changes to in_valid on other channels during XFER have no effect until the return to IDLE.
- A single-beat packet (valid and last on the first beat) goes IDLE→XFER→IDLE and is counted once.
- Reset mid-packet: the FSM returns to IDLE and the grant is dropped. Upstream must treat the partial packet as discarded. The block does not recover it.
- State encoding: IDLE=2'b00, XFER=2'b01. Other codes return to IDLE on the next edge.

Test Plan:
- Reset check: assert rst 3 cycles while in_valid=4'b1111 → out_valid=0, in_ready=0, dbg pkt_cnt=0 throughout. First grant after rst release is channel 0 (out_id=0).
- Fair rotation: all 4 channels hold 2-beat packets continuously, out_ready=1 → out_id sequence 0,1,2,3,0. Each packet is 2 beats followed by 1 idle cycle. pkt_cnt=5 after 5 packets.
- Skip non-requesters: last_id=1, in_valid=4'b1001 → channel 3 granted, then channel 0. Single requester channel 2 → granted back-to-back repeatedly.
- Backpressure and bubbles: granted channel 1 sends 4-beat packet D0..D3. Hold out_ready=0 for 3 cycles mid-packet, then drop in_valid[1] for 2 cycles → out_data order exactly D0..D3, no duplication. Grant stays on channel 1 and in_ready[0,2,3]=0 throughout.
- Single-beat packets: channels 0 and 2 each send 1-beat packets with last=1 → alternate 0,2,0,2. One beat every 2 cycles. pkt_cnt increments per beat.
- Reset mid-packet: rst asserted after 2 of 4 beats of channel 3 → next cycle out_valid=0 and state=IDLE. The next grant starts the search at channel 0.
